// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low code table and its inverse lookup.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  // Active-low g..a codes with dp off; must stay identical to the scan driver LUT.
  localparam logic [7:0] SEG_CODE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [4:0] seg_to_nibble(input logic [7:0] seg);
    logic [4:0] res;
    res = '0;
    for (int n = 0; n < 16; n++) begin
      if (seg == SEG_CODE[n]) res = {1'b1, 4'(n)};
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// Two-flop input synchronizer plus stability filter issuing one registered
// capture strobe per window in which the pattern held long enough.
module seg_stable_filter #(
  parameter int               WIDTH         = 16,
  parameter int               STABLE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic             strobe,
  output logic [WIDTH-1:0] dout
);

  localparam int             CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_HIT = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] prev;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= RESET_VAL;
      s      <= RESET_VAL;
      prev   <= RESET_VAL;
      cnt    <= '0;
      strobe <= 1'b0;
      dout   <= RESET_VAL;
    end else begin
      sync1 <= din;
      s     <= sync1;
      prev  <= s;
      if (s != prev) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      // Saturation at CNT_MAX guarantees the hit value is passed only once per window.
      strobe <= (s == prev) && (cnt == CNT_HIT);
      if ((s == prev) && (cnt == CNT_HIT)) dout <= s;
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reconstructs the 32-bit value shown on a scanned 8-digit 7-segment display,
// with per-digit valid flags, frame completion pulse and sticky error flags.
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  sel_in,
  input  logic [7:0]  seg_in,
  input  logic        clr_err,
  output logic [31:0] disp_data,
  output logic [7:0]  digit_valid,
  output logic        frame_done,
  output logic        seg_err,
  output logic        sel_err,
  output logic [2:0]  err_digit
);

  import seg7_pkg::*;

  logic                  strobe;
  logic [15:0]           cap;
  logic [7:0]            cap_sel;
  logic [7:0]            cap_seg;
  logic [2:0]            idx;
  logic [4:0]            lut;
  logic                  onehot;
  logic                  good;
  logic                  bad_seg;
  logic                  bad_sel;
  logic [NUM_DIGITS-1:0] seen;

  seg_stable_filter #(
    .WIDTH         (16),
    .STABLE_CYCLES (STABLE_CYCLES),
    .RESET_VAL     ({8'h00, 8'hFF})
  ) u_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .din     ({sel_in, seg_in}),
    .strobe  (strobe),
    .dout    (cap)
  );

  assign cap_sel = cap[15:8];
  assign cap_seg = cap[7:0];

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cap_sel[i]) idx = 3'(i);
    end
    onehot  = $onehot(cap_sel);
    lut     = seg_to_nibble(cap_seg);
    good    = strobe && onehot && lut[4];
    bad_seg = strobe && onehot && !lut[4];
    bad_sel = strobe && (cap_sel != '0) && !onehot;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_data   <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      seg_err     <= 1'b0;
      sel_err     <= 1'b0;
      err_digit   <= '0;
      seen        <= '0;
    end else begin
      // A completed mask is reported and cleared one cycle after the completing capture.
      frame_done <= (seen == '1);
      if (good) begin
        disp_data[{idx, 2'b00} +: 4] <= lut[3:0];
        digit_valid[idx]             <= 1'b1;
        seen <= ((seen == '1) ? '0 : seen) | (NUM_DIGITS'(1) << idx);
      end else if (seen == '1) begin
        seen <= '0;
      end

      if (bad_seg) begin
        seg_err   <= 1'b1;
        err_digit <= idx;
      end else if (clr_err) begin
        seg_err   <= 1'b0;
        err_digit <= '0;
      end

      if (bad_sel) begin
        sel_err <= 1'b1;
      end else if (clr_err) begin
        sel_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: a behavioural model predicts the
// outputs for each stimulus window, checks pop them after capture settles.
module tb_seg7_scan_decoder;

  localparam int SC = 16;

  logic        clk;
  logic        reset_n;
  logic [7:0]  sel_in;
  logic [7:0]  seg_in;
  logic        clr_err;
  logic [31:0] disp_data;
  logic [7:0]  digit_valid;
  logic        frame_done;
  logic        seg_err;
  logic        sel_err;
  logic [2:0]  err_digit;

  seg7_scan_decoder #(.STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sel_in      (sel_in),
    .seg_in      (seg_in),
    .clr_err     (clr_err),
    .disp_data   (disp_data),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .seg_err     (seg_err),
    .sel_err     (sel_err),
    .err_digit   (err_digit)
  );

  typedef struct {
    logic [31:0] disp;
    logic [7:0]  valid;
    logic        seg_err;
    logic        sel_err;
    logic [2:0]  err_digit;
    int          frames;
  } snap_t;

  snap_t sb_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int fd_pulses   = 0;
  int fd_high     = 0;
  int fd_cyc      = 0;
  logic fd_prev   = 1'b0;

  // reference model state
  logic [31:0] m_disp;
  logic [7:0]  m_valid;
  logic [7:0]  m_seen;
  logic        m_seg_err;
  logic        m_sel_err;
  logic [2:0]  m_err_digit;
  int          m_frames = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (frame_done) begin
        fd_high++;
        if (!fd_prev) begin
          fd_pulses++;
          fd_cyc = cyc;
        end
      end
      fd_prev = frame_done;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] code(input int n);
    case (n)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;  10: return 8'h88; 11: return 8'h83;
      12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  task automatic model_reset();
    m_disp = '0; m_valid = '0; m_seen = '0;
    m_seg_err = 1'b0; m_sel_err = 1'b0; m_err_digit = '0;
  endtask

  task automatic model_clear();
    m_seg_err = 1'b0; m_sel_err = 1'b0; m_err_digit = '0;
  endtask

  task automatic model_capture(input logic [7:0] sel, input logic [7:0] seg);
    int d;
    int nib;
    if (sel == 8'h00) return;
    if ($countones(sel) > 1) begin
      m_sel_err = 1'b1;
      return;
    end
    d = 0;
    for (int i = 0; i < 8; i++) if (sel[i]) d = i;
    nib = -1;
    for (int n = 0; n < 16; n++) if (code(n) == seg) nib = n;
    if (nib < 0) begin
      m_seg_err   = 1'b1;
      m_err_digit = 3'(d);
    end else begin
      m_disp[d*4 +: 4] = 4'(nib);
      m_valid[d]       = 1'b1;
      m_seen[d]        = 1'b1;
      if (m_seen == 8'hFF) begin
        m_frames++;
        m_seen = '0;
      end
    end
  endtask

  task automatic push_expect();
    snap_t e;
    e.disp = m_disp; e.valid = m_valid; e.seg_err = m_seg_err;
    e.sel_err = m_sel_err; e.err_digit = m_err_digit; e.frames = m_frames;
    sb_q.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    snap_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    @(negedge clk);
    chk({tag, "_disp"},   disp_data,   e.disp);
    chk({tag, "_valid"},  digit_valid, 32'(e.valid));
    chk({tag, "_segerr"}, 32'(seg_err), 32'(e.seg_err));
    chk({tag, "_selerr"}, 32'(sel_err), 32'(e.sel_err));
    chk({tag, "_errdig"}, 32'(err_digit), 32'(e.err_digit));
    chk({tag, "_frames"}, fd_pulses, e.frames);
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic [7:0] sel, input logic [7:0] seg, input int hold, input int gap);
    sel_in = sel;
    seg_in = seg;
    if (hold > SC) model_capture(sel, seg);
    cycles(hold);
    sel_in = 8'h00;
    seg_in = 8'hFF;
    cycles(gap);
  endtask

  // Error pattern whose capture edge coincides with a clr_err pulse.
  task automatic apply_clr(input logic [7:0] sel, input logic [7:0] seg);
    sel_in = sel;
    seg_in = seg;
    model_clear();
    model_capture(sel, seg);
    cycles(SC + 3);
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
    cycles(1);
    sel_in = 8'h00;
    seg_in = 8'hFF;
    cycles(4);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    model_clear();
    cycles(1);
    clr_err = 1'b0;
    cycles(2);
  endtask

  int d7_cyc;

  initial begin
    reset_n = 1'b0;
    sel_in  = 8'h00;
    seg_in  = 8'hFF;
    clr_err = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_disp",   disp_data, 32'h0);
    chk("rst_valid",  32'(digit_valid), 32'h0);
    chk("rst_fd",     32'(frame_done), 32'h0);
    chk("rst_errs",   32'({seg_err, sel_err, err_digit}), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    cycles(3);

    // single digit with exact latency check
    sel_in = 8'h04;
    seg_in = 8'hA4;
    model_capture(8'h04, 8'hA4);
    repeat (SC + 3) @(posedge clk);
    @(negedge clk);
    chk("sd_pre_disp",  disp_data, 32'h0);
    chk("sd_pre_valid", 32'(digit_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("sd_post_disp",  disp_data, 32'h0000_0200);
    chk("sd_post_valid", 32'(digit_valid), 32'h04);
    repeat (40 - (SC + 4)) @(posedge clk);
    #1;
    sel_in = 8'h00;
    seg_in = 8'hFF;
    cycles(4);
    push_expect();
    compare_out("single");

    // glitch rejection and hold-length boundary
    apply(8'h01, 8'hF9, 10, 4);
    push_expect();
    compare_out("glitch10");
    apply(8'h01, 8'hF9, SC, 4);
    push_expect();
    compare_out("hold16");
    apply(8'h01, 8'hF9, SC + 1, 4);
    push_expect();
    compare_out("hold17");

    // full frame 0x12345678
    for (int i = 0; i < 8; i++) begin
      if (i == 7) d7_cyc = cyc;
      apply(8'(1 << i), code(8 - i), 20, 3);
    end
    cycles(4);
    push_expect();
    compare_out("frame");
    chk("frame_fd_time", fd_cyc - d7_cyc, SC + 5);

    // error handling
    apply(8'h01, 8'h40, 20, 4);
    push_expect();
    compare_out("err_dp");
    pulse_clr();
    push_expect();
    compare_out("clr1");
    apply(8'h03, 8'hC0, 20, 4);
    push_expect();
    compare_out("err_sel");
    pulse_clr();
    apply(8'h20, 8'hFF, 20, 4);
    push_expect();
    compare_out("err_d5");
    apply_clr(8'h03, 8'hC0);
    push_expect();
    compare_out("clr_sel_coinc");
    apply_clr(8'h40, 8'h00);
    push_expect();
    compare_out("clr_seg_coinc");
    pulse_clr();

    // mid-frame reset
    for (int i = 0; i < 3; i++) apply(8'(1 << i), code(10 + i), 20, 3);
    push_expect();
    compare_out("mf_pre");
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mf_rst_disp",  disp_data, 32'h0);
    chk("mf_rst_valid", 32'(digit_valid), 32'h0);
    chk("mf_rst_errs",  32'({frame_done, seg_err, sel_err, err_digit}), 32'h0);
    model_reset();
    cycles(2);
    reset_n = 1'b1;
    cycles(3);
    for (int i = 3; i < 8; i++) apply(8'(1 << i), code(i), 20, 3);
    cycles(4);
    push_expect();
    compare_out("mf_part");
    for (int i = 0; i < 3; i++) apply(8'(1 << i), code(i + 4), 20, 3);
    cycles(4);
    push_expect();
    compare_out("mf_full");

    chk("fd_high_cycles", fd_high, m_frames);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
